// File: rtl/regfile_mp_sb_pkg.sv
// Shared constants, types and helpers for the multi-port register file
// with busy-bit scoreboard.
package regfile_mp_sb_pkg;

    localparam int DEFAULT_XLEN  = 32;
    localparam int DEFAULT_NREGS = 32;
    localparam int CNT_W         = 16;

    typedef logic [4:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

    // Adds 0..2 to a 16-bit counter, sticking at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_add16(input logic [CNT_W-1:0] base,
                                                   input logic [1:0]       inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, base} + {{(CNT_W-1){1'b0}}, inc};
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/regfile_sb.sv
// Busy-bit scoreboard: one pending-writeback flag per architectural register.
// Priority per register: flush clears all, then issue-set, then writeback-clear.
// Register 0 never goes busy.
// With REGFILE_BYPASS_EN defined, rd_busy is masked for a register that is
// being written back in the same cycle.
module regfile_sb
    import regfile_mp_sb_pkg::*;
#(
    parameter int NREGS  = DEFAULT_NREGS,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_WR-1:0]    wr_en,
    input  logic [NUM_WR*AW-1:0] wr_addr,
    input  logic                 sb_set_en,
    input  logic [AW-1:0]        sb_set_addr,
    input  logic                 sb_flush,
    input  logic [NUM_RD*AW-1:0] rd_addr,
    output logic [NUM_RD-1:0]    rd_busy
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [AW-1:0]    lookup_addr;
    logic             lookup_hit;

    // Next busy vector: apply lowest priority first so later steps override.
    always_comb begin
        busy_d = busy_q;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en[j]) begin
                busy_d[wr_addr[j*AW +: AW]] = 1'b0;
            end
        end
        if (sb_set_en && (sb_set_addr != AW'(REG_ZERO))) begin
            busy_d[sb_set_addr] = 1'b1;
        end
        if (sb_flush) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    // Busy vector register, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Per-read-port busy lookup, with optional same-cycle writeback masking.
    always_comb begin
        rd_busy     = '0;
        lookup_addr = '0;
        lookup_hit  = 1'b0;
        for (int i = 0; i < NUM_RD; i++) begin
            lookup_addr = rd_addr[i*AW +: AW];
            lookup_hit  = busy_q[lookup_addr] && (lookup_addr != AW'(REG_ZERO));
`ifdef REGFILE_BYPASS_EN
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en[j] && (wr_addr[j*AW +: AW] == lookup_addr)) begin
                    lookup_hit = 1'b0;
                end
            end
`endif
            rd_busy[i] = lookup_hit;
        end
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with busy-bit scoreboard for a dual-issue ID stage.
// Storage, write arbitration (higher port index wins), optional write-first
// bypass and the saturating count of writes aimed at register 0.
// Optional feature macro: REGFILE_BYPASS_EN (write-first read bypass).
module regfile_mp_sb
    import regfile_mp_sb_pkg::*;
#(
    parameter int XLEN   = DEFAULT_XLEN,
    parameter int NREGS  = DEFAULT_NREGS,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_RD*AW-1:0]   rd_addr,
    output logic [NUM_RD*XLEN-1:0] rd_data,
    output logic [NUM_RD-1:0]      rd_busy,
    input  logic [NUM_WR-1:0]      wr_en,
    input  logic [NUM_WR*AW-1:0]   wr_addr,
    input  logic [NUM_WR*XLEN-1:0] wr_data,
    input  logic                   sb_set_en,
    input  logic [AW-1:0]          sb_set_addr,
    input  logic                   sb_flush,
    output logic [CNT_W-1:0]       x0_wr_cnt
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [CNT_W-1:0] x0_cnt_q;
    logic [CNT_W-1:0] x0_cnt_d;
    logic [1:0]       x0_inc;
    logic [AW-1:0]    read_addr;
    logic [XLEN-1:0]  read_word;

    // Write arbitration: later ports overwrite earlier ones, so port 1 wins a
    // same-address collision; writes to register 0 only bump the counter.
    always_comb begin
        regs_d = regs_q;
        x0_inc = 2'd0;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en[j]) begin
                if (wr_addr[j*AW +: AW] == AW'(REG_ZERO)) begin
                    x0_inc = x0_inc + 2'd1;
                end else begin
                    regs_d[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
                end
            end
        end
        x0_cnt_d = sat_add16(x0_cnt_q, x0_inc);
    end

    // Register array and x0 write counter, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
            x0_cnt_q <= '0;
        end else begin
            regs_q   <= regs_d;
            x0_cnt_q <= x0_cnt_d;
        end
    end

    // Zero-latency read ports; register 0 is forced to read as zero.
    always_comb begin
        rd_data   = '0;
        read_addr = '0;
        read_word = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            read_addr = rd_addr[i*AW +: AW];
            read_word = (read_addr == AW'(REG_ZERO)) ? '0 : regs_q[read_addr];
`ifdef REGFILE_BYPASS_EN
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en[j] && (wr_addr[j*AW +: AW] == read_addr) &&
                    (read_addr != AW'(REG_ZERO))) begin
                    read_word = wr_data[j*XLEN +: XLEN];
                end
            end
`endif
            rd_data[i*XLEN +: XLEN] = read_word;
        end
    end

    assign x0_wr_cnt = x0_cnt_q;

    regfile_sb #(
        .NREGS  (NREGS),
        .NUM_RD (NUM_RD),
        .NUM_WR (NUM_WR)
    ) u_sb (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .sb_set_en   (sb_set_en),
        .sb_set_addr (sb_set_addr),
        .sb_flush    (sb_flush),
        .rd_addr     (rd_addr),
        .rd_busy     (rd_busy)
    );

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised successor to the single-write, dual-read register file in the ID stage.
- Configurable XLEN, register count, read-port count and write-port count. Supports a dual-issue datapath.
- Adds asynchronous clearing of all registers and deterministic multi-write priority.
- Adds a busy-bit scoreboard for load-use/writeback hazard detection, with a flush input for redirects.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; power of two, at least 2. AW = $clog2(NREGS).
- NUM_RD, 2, number of combinational read ports, 1..4.
- NUM_WR, 1, number of write ports, 1..2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- rd_addr  in  NUM_RD*AW  read addresses; port i is at [i*AW +: AW].
- rd_data  out  NUM_RD*XLEN  read data for port i.
- rd_busy  out  NUM_RD  scoreboard busy flag for the register addressed by port i.
- wr_en  in  NUM_WR  write enables.
- wr_addr  in  NUM_WR*AW  write addresses.
- wr_data  in  NUM_WR*XLEN  write data.
- sb_set_en  in  1  issue of an instruction with a pending destination register.
- sb_set_addr  in  AW  destination register being marked busy.
- sb_flush  in  1  clears all busy bits (pipeline redirect).
- x0_wr_cnt  out  16  saturating count of enabled writes addressed to register 0.

Behaviour:
- Reset (asynchronous assert, synchronous deassert by the integrator):
  - all registers 0, all busy bits 0, x0_wr_cnt = 0.
  - rd_data and rd_busy are combinational, so they read 0 while reset is asserted.
  - Reset mid-write: the write is discarded.
- Register 0:
  - always reads 0 and never goes busy.
  - writes to it are dropped; each enabled write port addressed to 0 increments x0_wr_cnt, +2 if both ports hit 0 in one cycle.
  - x0_wr_cnt saturates at 0xFFFF.
- Read:
  - 0-cycle latency: rd_data[i] = reg[rd_addr[i]], subject to the bypass rules below.
- Write:
  - register updates on the clk edge when wr_en[j] is set and wr_addr[j] != 0.
  - Same address on both ports in one cycle: port 1 wins, since it is the younger instruction.
- Scoreboard busy[r] next-state priority, highest first:
  - sb_flush -> busy[r] = 0 for every r.
  - sb_set_en && sb_set_addr == r && r != 0 -> busy[r] = 1. Set beats a same-cycle writeback clear, because the newer producer is outstanding.
  - any wr_en[j] && wr_addr[j] == r -> busy[r] = 0.
  - otherwise busy[r] holds.
- rd_busy[i] = busy[rd_addr[i]] & (rd_addr[i] != 0), subject to the bypass rules below.
- No FSM beyond the busy vector and the counter; there is no handshake.
- Out-of-range addresses cannot occur because NREGS is a power of two.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined (write-first):
  - if any wr_en[j] matches rd_addr[i] (non-zero), rd_data[i] returns that write data; port 1 wins when both match.
  - rd_busy[i] is masked to 0 for a register being written back in the same cycle.
- Undefined:
  - rd_data returns the stored (pre-edge) value; rd_busy reflects registered state only.
  - ID must stall one extra cycle on a writeback/read collision.

Decomposition:
- Pkg additions:
  - REG_ZERO constant (5'd0).
  - default XLEN/NREGS localparams.
  - typedef reg_addr_t (logic [4:0]).
- Sub-module regfile_sb: owns the busy vector, the set/clear/flush priority and the rd_busy lookup.
- The parent owns storage, write arbitration, bypass muxes and x0_wr_cnt.

Test Plan:
- Reset then read: reset pulsed with no clock edge, all rd_addr 1..31 -> rd_data = 0, rd_busy = 0.
- Two-port write conflict: NUM_WR = 2, wr_en = 2'b11, both addresses 5, wr_data = {0xBBBB_BBBB (port 1), 0xAAAA_AAAA (port 0)} -> next cycle reg5 = 0xBBBB_BBBB.
- x0 handling: write 0xDEADBEEF to x0 via both ports -> rd_data for x0 = 0, x0_wr_cnt = 2. 70000 further x0 writes -> count holds at 0xFFFF.
- Scoreboard set vs clear: set 7 in cycle N, writeback 7 in cycle N+3 while set 7 again in the same cycle -> busy7 = 1 after N+3. Writeback 7 at N+5 -> busy7 = 0.
- Flush: mark regs 3, 9, 12 busy, then sb_flush with sb_set_en on 3 in the same cycle -> all busy = 0 next cycle.
- Bypass: write 0x1234_5678 to x10 while rd_addr = 10 in the same cycle:
  - with REGFILE_BYPASS_EN -> rd_data = 0x1234_5678, rd_busy = 0.
  - without -> old value 0, then 0x1234_5678 the following cycle.
